// File: rtl/wb_mctrl_arb.sv
// -----------------------------------------------------------------------------
// wb_mctrl_arb
//
// Round-robin Wishbone B3 arbiter that lets NM bus masters share the single
// slave port of the wb_mctrl memory controller. A grant is registered and held
// for a whole incremental burst (cti = 3'b010). The arbiter releases the grant
// when the master drops cyc, when a classic/end-of-burst cycle terminates, or
// when the slave answers with err or rty. Every release is followed by at
// least one idle cycle with s_cyc_o low.
//
// Optional feature (compile-time macro WBARB_TIMEOUT_EN):
//   When defined, an 8-bit watchdog counts stalled strobe cycles and, on
//   reaching TO_CYCLES, terminates the access with a one-cycle err pulse to the
//   granted master while forcing s_cyc_o/s_stb_o low. When undefined, there is
//   no watchdog and TO_CYCLES is ignored.
//
// Parameters:
//   NM         number of masters (2..4)
//   TO_CYCLES  watchdog limit in cycles (watchdog builds only)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i     per-master controls, one bit per master
//   m_adr_i/m_dat_i            per-master address / write data, 32 bits each
//   m_sel_i/m_cti_i/m_bte_i    per-master select / cycle type / burst type
//   m_ack_o/m_err_o/m_rty_o    per-master terminations (granted master only)
//   m_dat_o                    read data, broadcast to every master
//   s_*_o                      request towards wb_mctrl (mirrors the grantee)
//   s_ack_i/s_err_i/s_rty_i    terminations from wb_mctrl
//   s_dat_i                    read data from wb_mctrl
//   gnt_o                      one-hot grant, zero while idle
// -----------------------------------------------------------------------------
module wb_mctrl_arb #(
   parameter int         NM        = 2,
   parameter logic [7:0] TO_CYCLES = 8'd255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NM-1:0]     m_cyc_i,
   input  logic [NM-1:0]     m_stb_i,
   input  logic [NM-1:0]     m_we_i,
   input  logic [NM*32-1:0]  m_adr_i,
   input  logic [NM*32-1:0]  m_dat_i,
   input  logic [NM*4-1:0]   m_sel_i,
   input  logic [NM*3-1:0]   m_cti_i,
   input  logic [NM*2-1:0]   m_bte_i,
   output logic [NM-1:0]     m_ack_o,
   output logic [NM-1:0]     m_err_o,
   output logic [NM-1:0]     m_rty_o,
   output logic [31:0]       m_dat_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [31:0]       s_adr_o,
   output logic [31:0]       s_dat_o,
   output logic [3:0]        s_sel_o,
   output logic [2:0]        s_cti_o,
   output logic [1:0]        s_bte_o,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   input  logic              s_rty_i,
   input  logic [31:0]       s_dat_i,
   output logic [NM-1:0]     gnt_o
);

   // Width of the encoded grant index; NM=2 needs one bit, NM=3/4 need two.
   localparam int GW = (NM > 2) ? 2 : 1;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t          r_state;
   state_t          w_state_nxt;
   logic [NM-1:0]   r_gnt;
   logic [NM-1:0]   w_gnt_nxt;
   logic [1:0]      r_last;
   logic [1:0]      w_last_nxt;
   logic [GW-1:0]   r_gidx;
   logic [GW-1:0]   w_gidx_nxt;

   // Signals of the currently granted master
   logic            w_cyc_g;
   logic            w_stb_g;
   logic            w_we_g;
   logic [31:0]     w_adr_g;
   logic [31:0]     w_dat_g;
   logic [3:0]      w_sel_g;
   logic [2:0]      w_cti_g;
   logic [1:0]      w_bte_g;

   // Arbitration
   logic            w_req_any;
   logic [GW-1:0]   w_pick;
   logic [NM-1:0]   w_pick_oh;
   int              w_dist;
   int              w_best;

   logic            w_busy;
   logic            w_term;
   logic            w_cti_end;
   logic            w_release;
   logic            w_to_fire;

   assign w_busy    = (r_state == ST_BUSY);
   assign w_term    = s_ack_i | s_err_i | s_rty_i;
   assign w_cti_end = (w_cti_g == CTI_CLASSIC) || (w_cti_g == CTI_EOB);

   // ---------------------------------------------------------------------------
   // Granted-master request mux
   // ---------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default before any
   // conditional assignment, so no path can leave it unassigned and infer a latch.
   always_comb begin : grant_mux
      w_cyc_g = 1'b0;
      w_stb_g = 1'b0;
      w_we_g  = 1'b0;
      w_adr_g = '0;
      w_dat_g = '0;
      w_sel_g = '0;
      w_cti_g = '0;
      w_bte_g = '0;
      for (int j = 0; j < NM; j++) begin
         if (r_gidx == GW'(j)) begin
            w_cyc_g = m_cyc_i[j];
            w_stb_g = m_stb_i[j];
            w_we_g  = m_we_i[j];
            w_adr_g = m_adr_i[32*j +: 32];
            w_dat_g = m_dat_i[32*j +: 32];
            w_sel_g = m_sel_i[4*j +: 4];
            w_cti_g = m_cti_i[3*j +: 3];
            w_bte_g = m_bte_i[2*j +: 2];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin pick: the requester at the smallest rotational distance past
   // r_last wins. The 2*NM bias keeps the modulo operand non-negative.
   // ---------------------------------------------------------------------------
   always_comb begin : rr_pick
      w_req_any = |m_cyc_i;
      w_pick    = '0;
      w_pick_oh = '0;
      w_dist    = 0;
      w_best    = NM;
      for (int j = 0; j < NM; j++) begin
         w_dist = (j + 2*NM - 1 - int'(r_last)) % NM;
         if (m_cyc_i[j] && (w_dist < w_best)) begin
            w_best       = w_dist;
            w_pick       = GW'(j);
            w_pick_oh    = '0;
            w_pick_oh[j] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Release: cyc dropped, classic/end-of-burst termination, err/rty with any
   // cti, or a watchdog expiry. An ack inside an incremental burst keeps BUSY.
   // ---------------------------------------------------------------------------
   assign w_release = !w_cyc_g
                    || (w_term && w_cti_end)
                    || s_err_i
                    || s_rty_i
                    || w_to_fire;

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin : fsm_next
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      w_gidx_nxt  = r_gidx;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = ST_BUSY;
               w_gnt_nxt   = w_pick_oh;
               w_last_nxt  = 2'(w_pick);
               w_gidx_nxt  = w_pick;
            end
         end
         ST_BUSY: begin
            if (w_release) begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_last  <= 2'(NM - 1);
         r_gidx  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
         r_gidx  <= w_gidx_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
`ifdef WBARB_TIMEOUT_EN
   logic [7:0] r_to_cnt;

   // Cleared while idle (so it starts from zero on every grant) and on every
   // termination; counts only cycles with an outstanding strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (!w_busy || w_term) begin
         r_to_cnt <= '0;
      end else if (w_cyc_g && w_stb_g && !w_to_fire) begin
         r_to_cnt <= r_to_cnt + 8'd1;
      end
   end

   assign w_to_fire = w_busy && (r_to_cnt == TO_CYCLES);
`else
   logic w_unused_to;
   assign w_unused_to = ^TO_CYCLES;
   assign w_to_fire   = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs: purely combinational paths in both directions, so the arbiter
   // adds no wait states inside a grant.
   // ---------------------------------------------------------------------------
   assign gnt_o   = r_gnt;
   assign m_dat_o = s_dat_i;

   assign s_cyc_o = w_busy & w_cyc_g & ~w_to_fire;
   assign s_stb_o = w_busy & w_stb_g & ~w_to_fire;
   assign s_we_o  = w_busy & w_we_g;
   assign s_adr_o = w_busy ? w_adr_g : '0;
   assign s_dat_o = w_busy ? w_dat_g : '0;
   assign s_sel_o = w_busy ? w_sel_g : '0;
   assign s_cti_o = w_busy ? w_cti_g : '0;
   assign s_bte_o = w_busy ? w_bte_g : '0;

   // r_gnt is one-hot in BUSY, so it doubles as the termination steering mask.
   assign m_ack_o = (w_busy && s_ack_i && !w_to_fire)         ? r_gnt : '0;
   assign m_err_o = (w_busy && (s_err_i || w_to_fire))        ? r_gnt : '0;
   assign m_rty_o = (w_busy && s_rty_i && !w_to_fire)         ? r_gnt : '0;

endmodule

// File: tb/tb_wb_mctrl_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_mctrl_arb
//
// Directed bench for wb_mctrl_arb (NM=2). Stimulus pushes the expected
// termination view into a scoreboard queue; a monitor pops and compares on
// every cycle in which the arbiter presents a termination to a master.
// Grant/idle timing is checked inline between transfers.
// -----------------------------------------------------------------------------
module tb_wb_mctrl_arb;

   localparam int NM = 2;

   localparam logic [2:0] T_ACK = 3'b001;
   localparam logic [2:0] T_ERR = 3'b010;
   localparam logic [2:0] T_RTY = 3'b100;

   localparam logic [2:0] CTI_CL  = 3'b000;
   localparam logic [2:0] CTI_INC = 3'b010;
   localparam logic [2:0] CTI_EOB = 3'b111;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
   logic [NM*32-1:0]  m_adr_i, m_dat_i;
   logic [NM*4-1:0]   m_sel_i;
   logic [NM*3-1:0]   m_cti_i;
   logic [NM*2-1:0]   m_bte_i;
   logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
   logic [31:0]       m_dat_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic [3:0]        s_sel_o;
   logic [2:0]        s_cti_o;
   logic [1:0]        s_bte_o;
   logic              s_ack_i, s_err_i, s_rty_i;
   logic [31:0]       s_dat_i;
   logic [NM-1:0]     gnt_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [NM-1:0] gnt;
      logic [NM-1:0] ack;
      logic [NM-1:0] err;
      logic [NM-1:0] rty;
      logic          cyc;
      logic [31:0]   adr;
      logic [31:0]   wdat;
      logic [31:0]   rdat;
      logic          we;
      logic [2:0]    cti;
      logic [3:0]    sel;
      logic [1:0]    bte;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   wb_mctrl_arb #(
      .NM        (NM),
      .TO_CYCLES (8'd16)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_adr_i (m_adr_i),
      .m_dat_i (m_dat_i),
      .m_sel_i (m_sel_i),
      .m_cti_i (m_cti_i),
      .m_bte_i (m_bte_i),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .m_rty_o (m_rty_o),
      .m_dat_o (m_dat_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_sel_o (s_sel_o),
      .s_cti_o (s_cti_o),
      .s_bte_o (s_bte_o),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .s_rty_i (s_rty_i),
      .s_dat_i (s_dat_i),
      .gnt_o   (gnt_o)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Master 1 drives bte=01, master 0 drives bte=00.
   function automatic logic [1:0] bte_of(input int m);
      return (m == 1) ? 2'b01 : 2'b00;
   endfunction

   task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [2:0] cti);
      m_cyc_i[m]            = cyc;
      m_stb_i[m]            = stb;
      m_we_i[m]             = we;
      m_adr_i[32*m +: 32]   = adr;
      m_dat_i[32*m +: 32]   = dat;
      m_sel_i[4*m +: 4]     = sel;
      m_cti_i[3*m +: 3]     = cti;
      m_bte_i[2*m +: 2]     = bte_of(m);
   endtask

   // Observe grant and s_cyc_o in the current cycle, then advance one cycle.
   task automatic peek(input string name, input logic [NM-1:0] g, input logic cyc);
      @(negedge clk);
      check({name, "_gnt"}, 32'(gnt_o), 32'(g));
      check({name, "_cyc"}, 32'(s_cyc_o), 32'(cyc));
      tick();
   endtask

   // One slave termination on the current cycle; the expected master-side view
   // goes into the scoreboard for the monitor.
   task automatic beat(input int m, input logic [2:0] term, input logic [31:0] rdat,
                       input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [2:0] cti, input logic [3:0] sel);
      exp_t          e;
      logic [NM-1:0] oh;
      oh    = '0;
      oh[m] = 1'b1;
      {s_rty_i, s_err_i, s_ack_i} = term;
      s_dat_i = rdat;
      e.gnt  = oh;
      e.ack  = term[0] ? oh : '0;
      e.err  = term[1] ? oh : '0;
      e.rty  = term[2] ? oh : '0;
      e.cyc  = 1'b1;
      e.adr  = adr;
      e.wdat = wdat;
      e.rdat = rdat;
      e.we   = we;
      e.cti  = cti;
      e.sel  = sel;
      e.bte  = bte_of(m);
      sb.push_back(e);
      tick();
      {s_rty_i, s_err_i, s_ack_i} = 3'b000;
      s_dat_i = '0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      m_cyc_i = '0;
      m_stb_i = '0;
      m_we_i  = '0;
      m_adr_i = '0;
      m_dat_i = '0;
      m_sel_i = '0;
      m_cti_i = '0;
      m_bte_i = '0;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_rty_i = 1'b0;
      s_dat_i = '0;
      tick();
      tick();
      @(negedge clk);
      check("rst_gnt", 32'(gnt_o), 32'(0));
      check("rst_cyc", 32'(s_cyc_o), 32'(0));
      check("rst_stb", 32'(s_stb_o), 32'(0));
      check("rst_adr", s_adr_o, 32'h0);
      check("rst_term", 32'({m_ack_o, m_err_o, m_rty_o}), 32'(0));
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares every presented termination with the scoreboard head.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if ((|m_ack_o) || (|m_err_o) || (|m_rty_o)) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon_unexpected: ack=%b err=%b rty=%b expected no termination",
                     m_ack_o, m_err_o, m_rty_o);
         end else begin
            mon_e = sb.pop_front();
            check("mon_gnt",  32'(gnt_o),   32'(mon_e.gnt));
            check("mon_ack",  32'(m_ack_o), 32'(mon_e.ack));
            check("mon_err",  32'(m_err_o), 32'(mon_e.err));
            check("mon_rty",  32'(m_rty_o), 32'(mon_e.rty));
            check("mon_cyc",  32'(s_cyc_o), 32'(mon_e.cyc));
            check("mon_stb",  32'(s_stb_o), 32'(mon_e.cyc));
            check("mon_adr",  s_adr_o,      mon_e.adr);
            check("mon_wdat", s_dat_o,      mon_e.wdat);
            check("mon_rdat", m_dat_o,      mon_e.rdat);
            check("mon_we",   32'(s_we_o),  32'(mon_e.we));
            check("mon_cti",  32'(s_cti_o), 32'(mon_e.cti));
            check("mon_sel",  32'(s_sel_o), 32'(mon_e.sel));
            check("mon_bte",  32'(s_bte_o), 32'(mon_e.bte));
         end
      end
   end

   // Hard stop in case something wedges the stimulus.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      // T1: single classic write from master 0
      do_reset();
      set_master(0, 1'b1, 1'b1, 1'b1, 32'h6000_0000, 32'h0, 4'hF, CTI_CL);
      peek("t1_idle", 2'b00, 1'b0);
      beat(0, T_ACK, 32'h0, 32'h6000_0000, 1'b1, 32'h0, CTI_CL, 4'hF);
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      peek("t1_release", 2'b00, 1'b0);

      // T2: simultaneous requests, round-robin order, one-cycle turnaround
      do_reset();
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h6000_0100, 32'h0, 4'hF, CTI_CL);
      set_master(1, 1'b1, 1'b1, 1'b1, 32'h6000_0200, 32'h1111_2222, 4'h3, CTI_CL);
      peek("t2_idle", 2'b00, 1'b0);
      beat(0, T_ACK, 32'hA5A5_0001, 32'h6000_0100, 1'b0, 32'h0, CTI_CL, 4'hF);
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      peek("t2_turn", 2'b00, 1'b0);
      beat(1, T_ACK, 32'h0, 32'h6000_0200, 1'b1, 32'h1111_2222, CTI_CL, 4'h3);
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h6000_0300, 32'h0, 4'hF, CTI_CL);
      peek("t2_turn2", 2'b00, 1'b0);
      beat(0, T_ACK, 32'hA5A5_0002, 32'h6000_0300, 1'b0, 32'h0, CTI_CL, 4'hF);
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      peek("t2_end", 2'b00, 1'b0);

      // T3: master 1 write burst while master 0 waits
      do_reset();
      set_master(1, 1'b1, 1'b1, 1'b1, 32'h6000_0000, 32'hB000_0000, 4'hF, CTI_INC);
      peek("t3_idle", 2'b00, 1'b0);
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h6000_0400, 32'h0, 4'hF, CTI_INC);
      for (int i = 0; i < 5; i++) begin
         set_master(1, 1'b1, 1'b1, 1'b1, 32'h6000_0000 + 32'(4*i), 32'hB000_0000 + 32'(i),
                    4'hF, (i == 4) ? CTI_EOB : CTI_INC);
         beat(1, T_ACK, 32'h0, 32'h6000_0000 + 32'(4*i), 1'b1, 32'hB000_0000 + 32'(i),
              (i == 4) ? CTI_EOB : CTI_INC, 4'hF);
      end
      set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      peek("t3_turn", 2'b00, 1'b0);

      // T4: master 0 read burst with one wait state; master 1 idle
      peek("t4_wait", 2'b01, 1'b1);
      for (int i = 0; i < 3; i++) begin
         set_master(0, 1'b1, 1'b1, 1'b0, 32'h6000_0400 + 32'(4*i), 32'h0, 4'hF,
                    (i == 2) ? CTI_EOB : CTI_INC);
         beat(0, T_ACK, 32'hC0DE_0000 + 32'(i), 32'h6000_0400 + 32'(4*i), 1'b0, 32'h0,
              (i == 2) ? CTI_EOB : CTI_INC, 4'hF);
      end
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      peek("t4_idle", 2'b00, 1'b0);

      // T5: reset asserted in the middle of a burst
      do_reset();
      set_master(0, 1'b1, 1'b1, 1'b1, 32'h6000_0000, 32'h7777_0000, 4'hF, CTI_INC);
      peek("t5_idle", 2'b00, 1'b0);
      beat(0, T_ACK, 32'h0, 32'h6000_0000, 1'b1, 32'h7777_0000, CTI_INC, 4'hF);
      set_master(1, 1'b1, 1'b1, 1'b0, 32'h6000_0500, 32'h0, 4'hF, CTI_CL);
      rst_n = 1'b0;
      tick();
      peek("t5_rst", 2'b00, 1'b0);
      rst_n = 1'b1;
      peek("t5_rel", 2'b00, 1'b0);
      set_master(0, 1'b1, 1'b1, 1'b1, 32'h6000_0004, 32'h7777_0001, 4'hF, CTI_CL);
      beat(0, T_ACK, 32'h0, 32'h6000_0004, 1'b1, 32'h7777_0001, CTI_CL, 4'hF);
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);

      // T6: err / rty release mid-burst, cyc drop release
      do_reset();
      set_master(0, 1'b1, 1'b1, 1'b1, 32'h6000_0800, 32'h0000_0005, 4'hF, CTI_INC);
      peek("t6_idle", 2'b00, 1'b0);
      beat(0, T_ERR, 32'h0, 32'h6000_0800, 1'b1, 32'h0000_0005, CTI_INC, 4'hF);
      peek("t6_err_idle", 2'b00, 1'b0);
      beat(0, T_RTY, 32'h0, 32'h6000_0800, 1'b1, 32'h0000_0005, CTI_INC, 4'hF);
      peek("t6_rty_idle", 2'b00, 1'b0);
      set_master(0, 1'b0, 1'b1, 1'b1, 32'h6000_0800, 32'h0000_0005, 4'hF, CTI_INC);
      peek("t6_drop", 2'b01, 1'b0);
      peek("t6_drop_idle", 2'b00, 1'b0);

      // T7: slave never answers
      do_reset();
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h6000_0900, 32'h0, 4'hF, CTI_CL);
      peek("t7_idle", 2'b00, 1'b0);
`ifdef WBARB_TIMEOUT_EN
      begin
         exp_t e;
         int   hit;
         e.gnt  = 2'b01;
         e.ack  = 2'b00;
         e.err  = 2'b01;
         e.rty  = 2'b00;
         e.cyc  = 1'b0;
         e.adr  = 32'h6000_0900;
         e.wdat = 32'h0;
         e.rdat = 32'h0;
         e.we   = 1'b0;
         e.cti  = CTI_CL;
         e.sel  = 4'hF;
         e.bte  = 2'b00;
         sb.push_back(e);
         hit = -1;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (m_err_o[0]) begin
               hit = n;
               break;
            end
         end
         check("t7_to_cycle", 32'(hit), 32'(16));
         check("t7_to_cyc", 32'(s_cyc_o), 32'(0));
         tick();
         set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
         peek("t7_to_idle", 2'b00, 1'b0);
      end
`else
      for (int n = 0; n < 100; n++) tick();
      peek("t7_hang", 2'b01, 1'b1);
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CL);
      peek("t7_drop", 2'b01, 1'b0);
      peek("t7_drop_idle", 2'b00, 1'b0);
`endif

      tick();
      tick();
      check("sb_empty", 32'(sb.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
